// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern modes, bar colour table and timing helpers.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_HOST  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    function automatic int unsigned timingTotal(input int unsigned active, input int unsigned fp,
                                                input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned cntWidth(input int unsigned total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

    // Bar colours left to right as {R,G,B} on/off bits.
    function automatic logic [2:0] barCode(input logic [2:0] idx);
        logic [2:0] code;
        code = 3'b000;
        case (idx)
            3'd0: code = 3'b111;
            3'd1: code = 3'b110;
            3'd2: code = 3'b011;
            3'd3: code = 3'b010;
            3'd4: code = 3'b101;
            3'd5: code = 3'b100;
            3'd6: code = 3'b001;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v counters with raw (unregistered, active-high) active, HS and VS flags.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    localparam int unsigned H_TOTAL = timingTotal(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = timingTotal(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned H_W     = cntWidth(H_TOTAL),
    localparam int unsigned V_W     = cntWidth(V_TOTAL)
) (
    input  logic           iVGA_CLK,
    input  logic           iRST_n,
    output logic [H_W-1:0] oHCnt,
    output logic [V_W-1:0] oVCnt,
    output logic           oActive,
    output logic           oHSync,
    output logic           oVSync
);

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            oHCnt <= '0;
            oVCnt <= '0;
        end else if (32'(oHCnt) == H_TOTAL - 1) begin
            oHCnt <= '0;
            oVCnt <= (32'(oVCnt) == V_TOTAL - 1) ? '0 : oVCnt + 1'b1;
        end else begin
            oHCnt <= oHCnt + 1'b1;
        end
    end

    assign oActive = (32'(oHCnt) < H_ACTIVE) && (32'(oVCnt) < V_ACTIVE);
    assign oHSync  = (32'(oHCnt) >= H_ACTIVE + H_FP) && (32'(oHCnt) < H_ACTIVE + H_FP + H_SYNC);
    // v_cnt only moves on the h wrap, so VS edges land on h_cnt = 0.
    assign oVSync  = (32'(oVCnt) >= V_ACTIVE + V_FP) && (32'(oVCnt) < V_ACTIVE + V_FP + V_SYNC);

endmodule

// File: rtl/vga_pixel_pipeline_ctrl.sv
// VGA output controller: pixel request stage, host-data slot, pattern mux and
// latency-matched sync/blank so that data and syncs leave the block together.
module vga_pixel_pipeline_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    localparam int unsigned H_TOTAL = timingTotal(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = timingTotal(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned H_W     = cntWidth(H_TOTAL),
    localparam int unsigned V_W     = cntWidth(V_TOTAL)
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    input  logic [1:0]         iMode,
    output logic               oRequest,
    output logic [H_W-1:0]     oX,
    output logic [V_W-1:0]     oY,
    output logic               oFrameStart,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK_n
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [H_W-1:0] hCnt;
    logic [V_W-1:0] vCnt;
    logic           active, hsRaw, vsRaw, frameStartNow;
    logic           hs1, vs1;
    logic           reqD, hsD, vsD;
    logic [H_W-1:0] xD;
    logic [V_W-1:0] yD;
    mode_e          modeLat;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) uTiming (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .oHCnt    (hCnt),
        .oVCnt    (vCnt),
        .oActive  (active),
        .oHSync   (hsRaw),
        .oVSync   (vsRaw)
    );

    assign frameStartNow = (hCnt == '0) && (vCnt == '0);

    // Stage 1: request, coordinates, frame pulse and the per-frame mode latch.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            oRequest    <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oFrameStart <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            modeLat     <= MODE_HOST;
        end else begin
            oRequest    <= active;
            oFrameStart <= frameStartNow;
            hs1         <= hsRaw;
            vs1         <= vsRaw;
            if (active) begin
                oX <= hCnt;
                oY <= vCnt;
            end
            if (frameStartNow) begin
                modeLat <= mode_e'(iMode);
            end
        end
    end

    // Host-data slot: everything requested last cycle, waiting for iRed/iGreen/iBlue.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            reqD <= 1'b0;
            xD   <= '0;
            yD   <= '0;
            hsD  <= 1'b0;
            vsD  <= 1'b0;
        end else begin
            reqD <= oRequest;
            xD   <= oX;
            yD   <= oY;
            hsD  <= hs1;
            vsD  <= vs1;
        end
    end

    logic [COLOR_W-1:0] patR, patG, patB;
    logic [2:0]         barRgb;
    logic               gridOn;

    always_comb begin
        patR   = '0;
        patG   = '0;
        patB   = '0;
        barRgb = barCode(3'(32'(xD) / BAR_W));
        gridOn = ((32'(xD) & 32'hF) == 32'd0) || ((32'(yD) & 32'hF) == 32'd0) ||
                 (32'(xD) == H_ACTIVE - 1) || (32'(yD) == V_ACTIVE - 1);
        unique case (modeLat)
            MODE_HOST: begin
                patR = iRed;
                patG = iGreen;
                patB = iBlue;
            end
            MODE_BARS: begin
                patR = {COLOR_W{barRgb[2]}};
                patG = {COLOR_W{barRgb[1]}};
                patB = {COLOR_W{barRgb[0]}};
            end
            MODE_GRID: begin
                patR = {COLOR_W{gridOn}};
                patG = {COLOR_W{gridOn}};
                patB = {COLOR_W{gridOn}};
            end
            MODE_BLACK: begin
                patR = '0;
                patG = '0;
                patB = '0;
            end
        endcase
    end

    // Stage 2: pixel, syncs and blank registered together.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_H_SYNC  <= ~HS_POL;
            oVGA_V_SYNC  <= ~VS_POL;
            oVGA_BLANK_n <= 1'b0;
        end else begin
            oVGA_R       <= reqD ? patR : '0;
            oVGA_G       <= reqD ? patG : '0;
            oVGA_B       <= reqD ? patB : '0;
            oVGA_H_SYNC  <= hsD ? HS_POL : ~HS_POL;
            oVGA_V_SYNC  <= vsD ? VS_POL : ~VS_POL;
            oVGA_BLANK_n <= reqD;
        end
    end

endmodule
